// File: rtl/alu_result_fifo.sv
// alu_result_fifo: registered output stage behind the 16-bit combinational ALU.
// Captures {opcode, result} with zero/negative flags computed at capture time
// and buffers them in a small FIFO presented through a valid/ready handshake.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready and out_valid depend only on the registered occupancy,
// so neither has a combinational path from the partner's valid/ready input.
module alu_result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int OPW   = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [OPW-1:0]   in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [OPW-1:0]   out_op,
  output logic             out_zero,
  output logic             out_neg,
  output logic [CW-1:0]    count,
  output logic [15:0]      total
);

  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] r_res  [DEPTH];
  logic [OPW-1:0]   r_op   [DEPTH];
  logic             r_zero [DEPTH];
  logic             r_neg  [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [15:0]      r_total;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CNT_MAX);
  assign w_empty = (r_count == '0);
  // Pop is gated by non-empty, so a push into an empty FIFO never bypasses.
  assign w_push  = in_valid & ~w_full;
  assign w_pop   = out_ready & ~w_empty;

  assign in_ready   = ~w_full;
  assign out_valid  = ~w_empty;
  assign out_result = r_res[r_rd_ptr];
  assign out_op     = r_op[r_rd_ptr];
  // Flags are forced low while nothing is presented so a reset-zero slot
  // does not read as a zero result.
  assign out_zero   = out_valid & r_zero[r_rd_ptr];
  assign out_neg    = out_valid & r_neg[r_rd_ptr];
  assign count      = r_count;
  assign total      = r_total;

  // Entry storage: write the incoming result and its capture-time flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_res[i]  <= '0;
        r_op[i]   <= '0;
        r_zero[i] <= 1'b0;
        r_neg[i]  <= 1'b0;
      end
    end else if (w_push) begin
      r_res[r_wr_ptr]  <= in_result;
      r_op[r_wr_ptr]   <= in_op;
      r_zero[r_wr_ptr] <= (in_result == '0);
      r_neg[r_wr_ptr]  <= in_result[WIDTH-1];
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Occupancy: unchanged on simultaneous push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Accepted-result counter, wraps modulo 2^16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_total <= '0;
    end else if (w_push) begin
      r_total <= r_total + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Testbench for alu_result_fifo: directed vectors, reference occupancy model
// and an expected-entry queue checked whenever the consumer takes the head.
module tb_alu_result_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int OPW   = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int EW    = OPW + WIDTH + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_result = '0;
  logic [OPW-1:0]   in_op = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_result;
  logic [OPW-1:0]   out_op;
  logic             out_zero;
  logic             out_neg;
  logic [CW-1:0]    count;
  logic [15:0]      total;

  alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_op(out_op),
    .out_zero(out_zero), .out_neg(out_neg),
    .count(count), .total(total)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];
  int          m_count = 0;
  logic [15:0] m_total = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor + model: sample away from the active edge, compare, then advance
  // the model to what the coming rising edge will do.
  always @(negedge clk) begin
    logic          m_push, m_pop;
    logic [EW-1:0] e;
    if (rst_n) begin
      check("in_ready", {31'b0, in_ready}, {31'b0, m_count < DEPTH});
      check("out_valid", {31'b0, out_valid}, {31'b0, m_count > 0});
      check("count", 32'(count), 32'(m_count));
      check("total", {16'b0, total}, {16'b0, m_total});
      m_push = in_valid && (m_count < DEPTH);
      m_pop  = out_ready && (m_count > 0);
      if (m_pop) begin
        if (exp_q.size() == 0) begin
          check("queue_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_op",     32'(out_op),     32'(e[EW-1 -: OPW]));
          check("out_result", 32'(out_result), 32'(e[WIDTH+1:2]));
          check("out_zero",   {31'b0, out_zero}, {31'b0, e[1]});
          check("out_neg",    {31'b0, out_neg},  {31'b0, e[0]});
        end
      end
      if (m_push) begin
        exp_q.push_back({in_op, in_result, (in_result == 16'h0), in_result[WIDTH-1]});
        m_total = m_total + 16'd1;
      end
      m_count = m_count + int'(m_push) - int'(m_pop);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [OPW-1:0] op,
                       input logic rdy);
    in_valid  = v;
    in_result = d;
    in_op     = op;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    exp_q.delete();
    m_count = 0;
    m_total = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (m_count > 0 && budget > 0) begin
      drive(1'b0, '0, '0, 1'b1);
      budget--;
    end
    if (m_count > 0) check("drain_timeout", 32'(m_count), 32'd0);
    out_ready = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    apply_reset();
    check("rst_count", 32'(count), 32'd0);
    check("rst_total", {16'b0, total}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_result", {16'b0, out_result}, 32'd0);
    check("rst_out_op", 32'(out_op), 32'd0);
    check("rst_out_zero", {31'b0, out_zero}, 32'd0);
    check("rst_out_neg", {31'b0, out_neg}, 32'd0);

    // Single push, one-cycle latency.
    drive(1'b1, 16'h36E6, 4'd1, 1'b0);
    check("t1_valid", {31'b0, out_valid}, 32'd1);
    check("t1_result", {16'b0, out_result}, 32'h36E6);
    check("t1_zero", {31'b0, out_zero}, 32'd0);
    check("t1_neg", {31'b0, out_neg}, 32'd0);
    check("t1_count", 32'(count), 32'd1);
    check("t1_total", {16'b0, total}, 32'd1);
    drain();

    // Negative then zero result, held, then popped in order.
    drive(1'b1, 16'h8666, 4'd2, 1'b0);
    drive(1'b1, 16'h0000, 4'd3, 1'b0);
    in_valid = 1'b0;
    check("t2_count", 32'(count), 32'd2);
    check("t2_head", {16'b0, out_result}, 32'h8666);
    check("t2_head_neg", {31'b0, out_neg}, 32'd1);
    check("t2_head_zero", {31'b0, out_zero}, 32'd0);
    drive(1'b0, '0, '0, 1'b1);
    check("t2_second", {16'b0, out_result}, 32'h0000);
    check("t2_second_zero", {31'b0, out_zero}, 32'd1);
    check("t2_second_neg", {31'b0, out_neg}, 32'd0);
    drive(1'b0, '0, '0, 1'b1);
    check("t2_empty_count", 32'(count), 32'd0);
    check("t2_empty_valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Overfill: fifth push rejected.
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 16'(i), 4'd4, 1'b0);
      if (i == 4) check("t3_full_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    check("t3_total", {16'b0, total}, 32'd4);
    check("t3_count", 32'(count), 32'd4);
    drain();

    // Sustained push+pop at 3 entries, pointers wrap.
    for (int i = 0; i < 3; i++) drive(1'b1, 16'h0010 + 16'(i), 4'd5, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'h0020 + 16'(i), 4'd6, 1'b1);
      check("t4_count", 32'(count), 32'd3);
    end
    in_valid = 1'b0;
    drain();

    // Push at empty with ready: no bypass. Then full with both high.
    drive(1'b1, 16'hABCD, 4'd7, 1'b1);
    check("t5_empty_push", 32'(count), 32'd1);
    for (int i = 0; i < 3; i++) drive(1'b1, 16'h0100 + 16'(i), 4'd8, 1'b0);
    check("t5_full", 32'(count), 32'd4);
    drive(1'b1, 16'hDEAD, 4'd9, 1'b1);
    check("t5_full_pop", 32'(count), 32'd3);
    in_valid = 1'b0;
    drain();

    // Asynchronous reset mid-cycle.
    for (int i = 0; i < 3; i++) drive(1'b1, 16'h0200 + 16'(i), 4'd10, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    m_count = 0;
    m_total = '0;
    #1;
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    check("t6_rst_total", {16'b0, total}, 32'd0);
    check("t6_rst_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Counter wrap: 65537 pushes with continuous pop.
    for (int i = 0; i < 65537; i++) drive(1'b1, 16'(i), 4'(i), 1'b1);
    in_valid = 1'b0;
    check("t6_total_wrap", {16'b0, total}, 32'h0001);
    drain();
    check("final_count", 32'(count), 32'd0);
    check("final_queue", 32'(exp_q.size()), 32'd0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_result_fifo.md
# alu_result_fifo

Registered output stage directly downstream of the 16-bit combinational ALU (bitwise_or and sibling operation units). It captures each ALU result with its opcode, computes zero/negative status flags at capture, and buffers entries in a small FIFO. Results are presented to the consumer through a valid/ready handshake, decoupling the combinational ALU from downstream timing.

## Interface
- WIDTH, 16, result width in bits
- DEPTH, 4, FIFO entries; power of two, minimum 2
- OPW, 4, opcode width in bits
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  ALU result present this cycle
- in_ready  output  1  FIFO can accept; equals not-full
- in_result  input  WIDTH  ALU result (e.g. bitwise_or out)
- in_op  input  OPW  opcode that produced in_result
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer accepts head entry
- out_result  output  WIDTH  head result
- out_op  output  OPW  head opcode
- out_zero  output  1  head result == 0
- out_neg  output  1  head result MSB
- count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH
- total  output  16  accepted-result counter, wraps 0xFFFF->0x0000

## Operation
- Push when in_valid && in_ready; pop when out_valid && out_ready.
- On push: store {in_op, in_result, zero, neg}; zero = (in_result == 0), neg = in_result[WIDTH-1]; flags computed from in_result, never recomputed at output.
- Storage: DEPTH-entry array, write pointer and read pointer each clog2(DEPTH) bits, wrapping modulo DEPTH; occupancy tracked by count register.
- out_* fields driven from the entry at the read pointer; values are don't-care when out_valid=0 but must not contain X after reset (storage reset to 0).
- Full (count==DEPTH): in_ready=0; in_valid ignored; no overwrite; total unchanged.
- Empty (count==0): out_valid=0; out_ready ignored; pointers unchanged.
- Simultaneous push and pop, 0<count<DEPTH: both occur; count unchanged.
- Simultaneous push and pop at empty: push only (no bypass); count 0->1.
- At full, in_ready=0, so only pop occurs even if in_valid=1; count DEPTH->DEPTH-1.
- total increments by 1 on every push, wraps modulo 2^16.
- Ordering: strict FIFO; no reordering, no drops.

## Timing
- Reset (rst_n low, asynchronous): count=0, total=0, pointers=0, all storage=0, out_valid=0, in_ready=1, out_result=0, out_op=0, out_zero=0, out_neg=0 (storage read at pointer 0 after reset, so out_zero reflects stored 0 only when gated; out_zero is forced 0 while out_valid=0).
- Reset assertion mid-operation discards all entries immediately; deassertion synchronous-safe, first push accepted on first rising edge after rst_n high.
- Latency: result pushed at edge N appears with out_valid=1 after edge N (visible in cycle N+1); minimum 1 cycle in-to-out.
- in_ready and out_valid are pure functions of registered count; no combinational path from in_valid to in_ready or from out_ready to out_valid.
- Throughput: one push and one pop per cycle sustained when 0<count<DEPTH.
- Consumer must hold out_ready meaningfully only when out_valid=1; producer may change in_result freely when in_ready=0.

## Test plan
- Reset then push in_result=0x36E6 (0x0666|0x3080), in_op=1 -> next cycle out_valid=1, out_result=0x36E6, out_zero=0, out_neg=0, count=1, total=1.
- Push 0x8666 (0x8666|0x0000) then 0x0000, out_ready=0 -> count=2; pop order 0x8666 (out_neg=1, out_zero=0) then 0x0000 (out_zero=1, out_neg=0); count returns to 0, out_valid=0.
- Push 5 back-to-back values 0x0001..0x0005 with out_ready=0, DEPTH=4 -> in_ready=0 after 4th; 5th not stored; total=4; drain yields 0x0001..0x0004 only.
- Fill to 3 entries, then hold in_valid=1 and out_ready=1 for 8 cycles with incrementing data -> count stays 3, outputs in order, pointers wrap past DEPTH without loss.
- Push at empty with out_ready=1 same cycle -> no pop that edge, count=1; with count=4 and in_valid=out_ready=1 -> count=3, input not taken.
- Push 3 entries, assert rst_n=0 asynchronously mid-cycle -> immediately count=0, out_valid=0, total=0, in_ready=1; preload total near 0xFFFF via 65537 pushes with continuous pop -> total wraps to 0x0001.
